// File: rtl/spi_master_arbiter.sv
// Round-robin scheduler sharing one SPI master between N_REQ requesters,
// with launch/transfer timeouts and a one-hot per-slave chip select fan-out.
module spi_master_arbiter #(
    parameter int N_REQ     = 2,
    parameter int DATA_W    = 16,
    parameter int LAUNCH_TO = 8,
    parameter int XFER_TO   = 512
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [2*N_REQ-1:0]        req_mode,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [N_REQ-1:0]          err,
    input  logic                      m_cs,
    output logic                      m_strt,
    output logic [DATA_W-1:0]         m_data_in,
    output logic                      m_ckp,
    output logic                      m_cph,
    output logic [N_REQ-1:0]          cs_out
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int TO_MAX = (LAUNCH_TO > XFER_TO) ? LAUNCH_TO : XFER_TO;
    localparam int TMR_W  = ($clog2(TO_MAX) > 0) ? $clog2(TO_MAX) : 1;

    localparam logic [TMR_W-1:0] TMR_SAT     = '1;
    localparam logic [TMR_W-1:0] LAUNCH_LAST = TMR_W'(LAUNCH_TO - 1);
    localparam logic [TMR_W-1:0] XFER_LAST   = TMR_W'(XFER_TO - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, ACTIVE, RELEASE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  pick;
    logic              any_req;
    logic [DATA_W-1:0] pick_data;
    logic [1:0]        pick_mode;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_inc;

    // Scan offsets from the highest down so the smallest offset from ptr wins.
    always_comb begin
        int idx;
        logic [IDX_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        pick    = '0;
        any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDX_W'(idx);
            if (req[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        pick_data = '0;
        pick_mode = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (pick == IDX_W'(j)) begin
                pick_data = req_data[j*DATA_W +: DATA_W];
                pick_mode = req_mode[2*j +: 2];
            end
        end
    end

    assign timer_inc = (timer == TMR_SAT) ? timer : timer + 1'b1;

    // Combinational so the slave select follows the master CS edge-for-edge.
    always_comb begin
        cs_out = '1;
        if (state == LAUNCH || state == ACTIVE) cs_out[sel] = m_cs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            timer     <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= '0;
            m_strt    <= 1'b0;
            m_data_in <= '0;
            m_ckp     <= 1'b0;
            m_cph     <= 1'b0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel       <= pick;
                        gnt       <= N_REQ'(1) << pick;
                        m_data_in <= pick_data;
                        m_ckp     <= pick_mode[1];
                        m_cph     <= pick_mode[0];
                        m_strt    <= 1'b1;
                        timer     <= '0;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!m_cs) begin
                        m_strt <= 1'b0;
                        timer  <= '0;
                        state  <= ACTIVE;
                    end else if (timer == LAUNCH_LAST) begin
                        err[sel] <= 1'b1;
                        m_strt   <= 1'b0;
                        state    <= RELEASE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ACTIVE: begin
                    // Any high sample of the master CS ends the transfer, glitches included.
                    if (m_cs) begin
                        done[sel] <= 1'b1;
                        state     <= RELEASE;
                    end else if (timer == XFER_LAST) begin
                        err[sel] <= 1'b1;
                        state    <= RELEASE;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                RELEASE: begin
                    gnt   <= '0;
                    ptr   <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Randomized bench for spi_master_arbiter: a transaction-level round-robin and
// timing model predicts every registered output and cs_out cycle by cycle.
module tb_spi_master_arbiter;

    localparam int N_REQ     = 2;
    localparam int DATA_W    = 16;
    localparam int LAUNCH_TO = 8;
    localparam int XFER_TO   = 512;

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [2*N_REQ-1:0]      req_mode;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [N_REQ-1:0]        err;
    logic                    m_cs;
    logic                    m_strt;
    logic [DATA_W-1:0]       m_data_in;
    logic                    m_ckp;
    logic                    m_cph;
    logic [N_REQ-1:0]        cs_out;

    int checks = 0;
    int passed = 0;
    int rr_ptr = 0;
    logic [DATA_W-1:0] last_data;
    logic [1:0]        last_mode;

    spi_master_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .LAUNCH_TO(LAUNCH_TO), .XFER_TO(XFER_TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
        .gnt(gnt), .done(done), .err(err), .m_cs(m_cs), .m_strt(m_strt),
        .m_data_in(m_data_in), .m_ckp(m_ckp), .m_cph(m_cph), .cs_out(cs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, observed running required finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] packVals(input logic [DATA_W-1:0] data, input logic ckp,
                                             input logic cph, input logic [N_REQ-1:0] g,
                                             input logic [N_REQ-1:0] dn, input logic [N_REQ-1:0] er,
                                             input logic strt, input logic [N_REQ-1:0] cs);
        return 64'({data, ckp, cph, g, dn, er, strt, cs});
    endfunction

    function automatic logic [63:0] obsPack();
        return packVals(m_data_in, m_ckp, m_cph, gnt, done, err, m_strt, cs_out);
    endfunction

    function automatic int pickWinner();
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (rr_ptr + k) % N_REQ;
            if (req[i]) return i;
        end
        return 0;
    endfunction

    task automatic applyStimulus(input int i);
        req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        req_mode[2*i +: 2]           = 2'($urandom);
        req[i]                       = 1'b1;
    endtask

    task automatic idleCheck(input int n, input string tag);
        repeat (n) begin
            @(negedge clk); #1;
            checkOutput(tag, obsPack(),
                        packVals(last_data, last_mode[1], last_mode[0], '0, '0, '0, 1'b0, '1));
        end
    endtask

    // d: cycles after grant before the master pulls CS low (>= LAUNCH_TO means never);
    // l: cycles CS stays low once sampled (>= XFER_TO means never); abort_c: reset at that cycle.
    task automatic runTransfer(input int d, input int l, input int abort_c,
                               input bit drop_mid, input string tag);
        int w, e_cyc;
        bit is_err;
        logic [DATA_W-1:0] xd;
        logic [1:0] xm;
        logic [N_REQ-1:0] onehot, cs_exp, dn, er;
        logic mcs, strt;
        w  = pickWinner();
        xd = req_data[w*DATA_W +: DATA_W];
        xm = req_mode[2*w +: 2];
        onehot = '0;
        onehot[w] = 1'b1;
        if (d >= LAUNCH_TO) begin
            e_cyc = LAUNCH_TO; is_err = 1'b1;
        end else if (l >= XFER_TO) begin
            e_cyc = d + 1 + XFER_TO; is_err = 1'b1;
        end else begin
            e_cyc = d + 2 + l; is_err = 1'b0;
        end
        for (int c = 0; c <= e_cyc; c++) begin
            @(negedge clk);
            mcs  = (c >= d && c < d + 1 + l && c < e_cyc) ? 1'b0 : 1'b1;
            m_cs = mcs;
            if (drop_mid && c == 2) begin
                req[w] = 1'b0;
                req_data[w*DATA_W +: DATA_W] = ~xd;
                req_mode[2*w +: 2]           = ~xm;
            end
            #1;
            cs_exp = '1;
            if (c < e_cyc) cs_exp[w] = mcs;
            dn = '0;
            er = '0;
            if (c == e_cyc) begin
                if (is_err) er[w] = 1'b1;
                else        dn[w] = 1'b1;
            end
            strt = (c <= d && c < LAUNCH_TO && c < e_cyc);
            checkOutput(tag, obsPack(), packVals(xd, xm[1], xm[0], onehot, dn, er, strt, cs_exp));
            if (c == abort_c) begin
                rst = 1'b1;
                @(negedge clk); #1;
                checkOutput({tag, "_rst"}, obsPack(), packVals('0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '1));
                rst = 1'b0;
                m_cs = 1'b1;
                rr_ptr = 0;
                last_data = '0;
                last_mode = '0;
                return;
            end
        end
        req[w] = 1'b0;
        rr_ptr = (w + 1) % N_REQ;
        last_data = xd;
        last_mode = xm;
        @(negedge clk); #1;
        checkOutput({tag, "_rel"}, obsPack(), packVals(xd, xm[1], xm[0], '0, '0, '0, 1'b0, '1));
    endtask

    initial begin
        int d, l, r;
        rst = 1'b1; m_cs = 1'b1; req = '0; req_data = '0; req_mode = '0;
        last_data = '0; last_mode = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset", obsPack(), packVals('0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '1));
        rst = 1'b0;
        idleCheck(2, "idle");

        req_data[15:0] = 16'hA5C3;
        req_mode[1:0]  = 2'b10;
        req = 2'b01;
        runTransfer(2, 200, -1, 1'b0, "t1_basic");

        req = '1;
        for (int i = 0; i < 4; i++) begin
            runTransfer(int'($urandom_range(0, 3)), int'($urandom_range(1, 10)), -1, 1'b0, "t2_rr");
            if (i < 3) req = '1;
        end

        runTransfer(1000, 0, -1, 1'b0, "t3_launch_to");
        idleCheck(2, "t3_idle");

        for (int i = 0; i < N_REQ; i++) applyStimulus(i);
        runTransfer(1, 100000, -1, 1'b0, "t4_xfer_to");
        runTransfer(0, 5, -1, 1'b0, "t4_next");

        applyStimulus(0);
        runTransfer(LAUNCH_TO - 1, XFER_TO - 1, -1, 1'b0, "bound_late");

        if (rr_ptr != 0) begin
            applyStimulus(N_REQ - 1);
            runTransfer(0, 3, -1, 1'b0, "t5_align");
        end
        for (int i = 0; i < N_REQ; i++) applyStimulus(i);
        runTransfer(1, 1000, 6, 1'b0, "t5_abort");
        runTransfer(0, 4, -1, 1'b0, "t5_after");

        req = '0;
        applyStimulus(1);
        runTransfer(1, 8, -1, 1'b1, "t6_drop");

        repeat (40) begin
            if (req == '0 && $urandom_range(0, 3) == 0) idleCheck(int'($urandom_range(1, 3)), "gap");
            for (int i = 0; i < N_REQ; i++)
                if (!req[i] && ($urandom_range(0, 1) == 1)) applyStimulus(i);
            if (req == '0) applyStimulus(int'($urandom_range(0, N_REQ - 1)));
            d = int'($urandom_range(0, LAUNCH_TO + 1));
            r = int'($urandom_range(0, 9));
            l = (r == 0) ? XFER_TO - 1 : (r == 1) ? XFER_TO : int'($urandom_range(0, 15));
            runTransfer(d, l, -1, ($urandom_range(0, 3) == 0), "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Round-robin scheduler that shares one SPI master (transmitter) between N_REQ requesters. Each requester targets its own slave.
- Latches the winner's 16-bit word and SPI mode, then drives the master's strt/data_in/CKP/CPH.
- Tracks transaction completion through the master's CS output.
- Fans the master CS out to a one-hot per-slave chip select.
- Sits between the CPU-side requesters and the SPI master, with per-transaction timeout protection.

Parameters:
N_REQ, 2, number of requesters and slave chip selects (2..8)
DATA_W, 16, transfer word width; matches master data_in
LAUNCH_TO, 8, max clk cycles to wait for master CS to fall after strt
XFER_TO, 512, max clk cycles to wait for master CS to rise once active

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  N_REQ  per-requester transfer request, level, held until done/err
req_data  in  N_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]
req_mode  in  2*N_REQ  requester i mode at [2i+1:2i] = {CKP,CPH}
gnt  out  N_REQ  one-hot grant, high from grant through release
done  out  N_REQ  one-cycle pulse, transfer i completed normally
err  out  N_REQ  one-cycle pulse, transfer i timed out
m_cs  in  1  chip select from master (low = transfer active)
m_strt  out  1  start strobe to master
m_data_in  out  DATA_W  word to master, latched at grant
m_ckp  out  1  clock polarity to master, latched at grant
m_cph  out  1  clock phase to master, latched at grant
cs_out  out  N_REQ  per-slave chip select, active-low

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, ptr=0, timer=0. gnt=0, done=0, err=0, m_strt=0, m_data_in=0, m_ckp=0, m_cph=0. cs_out all ones. Reset mid-transfer aborts immediately: no done/err pulse, and cs_out returns to all ones on the following edge.
- State encoding: IDLE, LAUNCH, ACTIVE, RELEASE. All outputs are registered except cs_out.
- IDLE:
  - If any req is high, choose the first requester scanning ptr, ptr+1, ... mod N_REQ.
  - Next edge: gnt[sel]=1; latch m_data_in, m_ckp, m_cph from sel; m_strt=1; timer=0; go to LAUNCH.
  - Latency from req rising to gnt/m_strt is 1 clk.
- LAUNCH:
  - Hold m_strt=1 and the latched config; timer increments each cycle.
  - m_cs==0 sampled: m_strt=0, timer=0, go to ACTIVE.
  - Otherwise, timer==LAUNCH_TO-1: err[sel] pulses, m_strt=0, go to RELEASE.
- ACTIVE:
  - m_strt=0; config held stable; timer increments.
  - m_cs==1 sampled: done[sel] pulses, go to RELEASE.
  - Otherwise, timer==XFER_TO-1: err[sel] pulses, go to RELEASE.
- RELEASE (1 cycle): gnt=0; ptr=(sel+1) mod N_REQ; go to IDLE. A new grant is possible on the next cycle, so the minimum gap between transfers is 1 idle cycle.
- done and err are mutually exclusive and last exactly one cycle. They assert on the same edge the state leaves LAUNCH/ACTIVE.
- cs_out[j] = m_cs when j==sel and state is LAUNCH or ACTIVE; otherwise 1. It is combinational so it aligns with SCK.
- Dropping req after grant does not abort; the transfer still completes with a done pulse.
- req/req_data/req_mode changes after grant are ignored until the next grant.
- Simultaneous requests are served strictly round-robin. Each requester that holds req waits at most N_REQ-1 other transfers.
- The timer is sized $clog2(max(LAUNCH_TO,XFER_TO)) bits and saturates; it never wraps.
- A master CS glitch high during ACTIVE is treated as completion.

Test Plan:
1. Reset then req=2'b01, req_data[15:0]=16'hA5C3, req_mode[1:0]=2'b10 -> next clk gnt=01, m_strt=1, m_data_in=A5C3, m_ckp=1, m_cph=0. Model m_cs falls 2 clk later and rises 200 clk later -> cs_out=2'b10 while low; done[0] one-cycle pulse; gnt=00 one clk after.
2. req=2'b11 continuously, ptr=0 -> service order 0,1,0,1. Each done is followed by exactly 1 IDLE cycle before the next gnt.
3. Model never pulls m_cs low -> m_strt held high for 8 clk, then err[0] pulse, no done, gnt released, cs_out stays 2'b11.
4. m_cs held low forever after launch -> err pulse at 512 clk in ACTIVE, then the next requester is granted.
5. rst=1 during ACTIVE -> next clk gnt=0, m_strt=0, cs_out=2'b11, no done/err. With req still high after reset, requester 0 is granted (ptr=0).
6. req[1] dropped mid-transfer and req_data changed -> m_data_in unchanged, done[1] still pulses.
